cpu_seq_ctrl: RTL and testbench

Instruction-sequencing controller for the 8-bit accumulator CPU. It runs the 8-phase fetch/execute cycle and decodes the 3-bit opcode from the instruction register into per-phase strobes for memory, IR, PC, accumulator and the ALU path. It also owns halt/resume handling, a single-step debug mode and a retired-instruction counter. It sits between the instruction register/ALU zero flag and the memory, PC and accumulator load enables.

---
 rtl/cpu_seq_ctrl_if.sv | 33 +++
 rtl/cpu_seq_ctrl.sv | 143 ++++++++++++++
 tb/tb_cpu_seq_ctrl.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/cpu_seq_ctrl_if.sv
// Sequencer-to-datapath bundle: IR opcode/flags and debug controls in,
// phase, strobes, stall and retired-instruction count out.
interface cpu_seq_ctrl_if #(
    parameter int CNT_WIDTH = 16
);
    logic [2:0]           opcode;
    logic                 zero;
    logic                 resume;
    logic                 step_en;
    logic                 step;
    logic [2:0]           phase;
    logic                 mem_rd;
    logic                 load_ir;
    logic                 inc_pc;
    logic                 load_ac;
    logic                 load_pc;
    logic                 mem_wr;
    logic                 halt;
    logic                 stalled;
    logic [CNT_WIDTH-1:0] instr_cnt;

    modport master (
        output opcode, zero, resume, step_en, step,
        input  phase, mem_rd, load_ir, inc_pc, load_ac, load_pc, mem_wr,
               halt, stalled, instr_cnt
    );

    modport slave (
        input  opcode, zero, resume, step_en, step,
        output phase, mem_rd, load_ir, inc_pc, load_ac, load_pc, mem_wr,
               halt, stalled, instr_cnt
    );
endinterface

// File: rtl/cpu_seq_ctrl.sv
// 8-phase fetch/execute sequencer for the accumulator CPU with halt/resume,
// single-step debug and a retired-instruction counter.
module cpu_seq_ctrl #(
    parameter int CNT_WIDTH = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    cpu_seq_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        INST_ADDR  = 3'd0,
        INST_FETCH = 3'd1,
        INST_LOAD  = 3'd2,
        IDLE       = 3'd3,
        OP_ADDR    = 3'd4,
        OP_FETCH   = 3'd5,
        ALU_OP     = 3'd6,
        STORE      = 3'd7
    } phase_t;

    typedef enum logic [2:0] {
        OP_HLT = 3'b000,
        OP_SKZ = 3'b001,
        OP_ADD = 3'b010,
        OP_AND = 3'b011,
        OP_XOR = 3'b100,
        OP_LDA = 3'b101,
        OP_STO = 3'b110,
        OP_JMP = 3'b111
    } opcode_t;

    phase_t               phase_q, phase_d;
    logic                 halted_q, halted_d;
    logic                 step_wait_q, step_wait_d;
    logic                 boot_q;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    opcode_t op;
    logic    aluop;
    logic    waiting;
    logic    mem_rd, load_ir, inc_pc, load_ac, load_pc, mem_wr, halt;

    assign op    = opcode_t'(bus.opcode);
    assign aluop = (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);

    // The first phase 0 after reset behaves as if a 7->0 transition just happened.
    assign waiting = step_wait_q || (boot_q && rst_n && bus.step_en && (phase_q == INST_ADDR));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q     <= INST_ADDR;
            halted_q    <= 1'b0;
            step_wait_q <= 1'b0;
            boot_q      <= 1'b1;
            cnt_q       <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            phase_q     <= phase_d;
            halted_q    <= halted_d;
            step_wait_q <= step_wait_d;
            boot_q      <= 1'b0;
            cnt_q       <= cnt_d;
        end
    end

    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        phase_d     = phase_q;
        halted_d    = halted_q;
        step_wait_d = step_wait_q;
        cnt_d       = cnt_q;
        mem_rd      = 1'b0;
        load_ir     = 1'b0;
        inc_pc      = 1'b0;
        load_ac     = 1'b0;
        load_pc     = 1'b0;
        mem_wr      = 1'b0;
        halt        = 1'b0;

        if (halted_q) begin
            if (bus.resume) begin
                halted_d = 1'b0;
                phase_d  = OP_FETCH;
            end
        end else if (waiting) begin
            if (bus.step || !bus.step_en) begin
                step_wait_d = 1'b0;
                phase_d     = INST_FETCH;
            end else begin
                step_wait_d = 1'b1;
            end
        end else if (phase_q == OP_ADDR && op == OP_HLT) begin
            halted_d = 1'b1;
        end else begin
            phase_d = phase_t'(phase_q + 3'd1);
            if (phase_q == STORE) begin
                cnt_d       = cnt_q + CNT_WIDTH'(1);
                step_wait_d = bus.step_en;
            end
        end

        if (halted_q) begin
            halt = 1'b1;
        end else begin
            case (phase_q)
                INST_FETCH: mem_rd = 1'b1;
                INST_LOAD, IDLE: begin
                    mem_rd  = 1'b1;
                    load_ir = 1'b1;
                end
                OP_ADDR: begin
                    inc_pc = 1'b1;
                    halt   = (op == OP_HLT);
                end
                OP_FETCH: mem_rd = aluop;
                ALU_OP: begin
                    mem_rd  = aluop;
                    inc_pc  = (op == OP_SKZ) && bus.zero;
                    load_pc = (op == OP_JMP);
                end
                STORE: begin
                    mem_rd  = aluop;
                    load_ac = aluop;
                    inc_pc  = (op == OP_JMP);
                    load_pc = (op == OP_JMP);
                    mem_wr  = (op == OP_STO);
                end
                default: ;
            endcase
        end
    end

    assign bus.phase     = phase_q;
    assign bus.mem_rd    = mem_rd;
    assign bus.load_ir   = load_ir;
    assign bus.inc_pc    = inc_pc;
    assign bus.load_ac   = load_ac;
    assign bus.load_pc   = load_pc;
    assign bus.mem_wr    = mem_wr;
    assign bus.halt      = halt;
    assign bus.stalled   = halted_q || waiting;
    assign bus.instr_cnt = cnt_q;
endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Bench for cpu_seq_ctrl: directed scenarios plus randomized traffic, every
// cycle compared against a phase-table reference model.
module tb_cpu_seq_ctrl;
    localparam logic [2:0] HLT = 3'd0, SKZ = 3'd1, ADD = 3'd2, ANDO = 3'd3,
                           XORO = 3'd4, LDA = 3'd5, STO = 3'd6, JMP = 3'd7;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cpu_seq_ctrl_if #(.CNT_WIDTH(16)) bus ();
    cpu_seq_ctrl_if #(.CNT_WIDTH(2))  bus2 ();

    assign bus2.opcode  = bus.opcode;
    assign bus2.zero    = bus.zero;
    assign bus2.resume  = bus.resume;
    assign bus2.step_en = bus.step_en;
    assign bus2.step    = bus.step;

    cpu_seq_ctrl #(.CNT_WIDTH(16)) u_dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
    cpu_seq_ctrl #(.CNT_WIDTH(2))  u_dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    int n_checks = 0;
    int n_pass   = 0;

    // Reference state: where the instruction cycle is, and whether it is frozen.
    int m_phase;
    int m_cnt;
    bit m_halted;
    bit m_wait;
    bit m_boot;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at t=%0t", tag, act, exp, $time);
    endtask

    task automatic model_reset();
        m_phase  = 0;
        m_cnt    = 0;
        m_halted = 1'b0;
        m_wait   = 1'b0;
        m_boot   = 1'b1;
    endtask

    task automatic check_all();
        bit alu, h, live;
        logic [2:0] op;
        op   = bus.opcode;
        h    = m_halted;
        live = !h;
        alu  = (op == ADD) || (op == ANDO) || (op == XORO) || (op == LDA);
        check("phase",   32'(bus.phase), 32'(m_phase));
        check("mem_rd",  32'(bus.mem_rd),
              32'(live && ((m_phase >= 1 && m_phase <= 3) || (m_phase >= 5 && alu))));
        check("load_ir", 32'(bus.load_ir), 32'(live && (m_phase == 2 || m_phase == 3)));
        check("inc_pc",  32'(bus.inc_pc),
              32'(live && (m_phase == 4 || (m_phase == 6 && op == SKZ && bus.zero)
                           || (m_phase == 7 && op == JMP))));
        check("load_ac", 32'(bus.load_ac), 32'(live && m_phase == 7 && alu));
        check("load_pc", 32'(bus.load_pc), 32'(live && m_phase >= 6 && op == JMP));
        check("mem_wr",  32'(bus.mem_wr),  32'(live && m_phase == 7 && op == STO));
        check("halt",    32'(bus.halt),    32'(h || (m_phase == 4 && op == HLT)));
        check("stalled", 32'(bus.stalled),
              32'(h || m_wait || (m_boot && rst_n && bus.step_en && m_phase == 0)));
        check("instr_cnt",  32'(bus.instr_cnt),  32'(m_cnt % 65536));
        check("instr_cnt2", 32'(bus2.instr_cnt), 32'(m_cnt % 4));
    endtask

    task automatic model_edge();
        bit waiting;
        waiting = m_wait || (m_boot && bus.step_en && m_phase == 0);
        if (m_halted) begin
            if (bus.resume) begin
                m_halted = 1'b0;
                m_phase  = 5;
            end
        end else if (waiting) begin
            if (bus.step || !bus.step_en) begin
                m_wait  = 1'b0;
                m_phase = 1;
            end else begin
                m_wait = 1'b1;
            end
        end else if (m_phase == 4 && bus.opcode == HLT) begin
            m_halted = 1'b1;
        end else begin
            m_phase = (m_phase + 1) % 8;
            if (m_phase == 0) begin
                m_cnt++;
                m_wait = bus.step_en;
            end
        end
        m_boot = 1'b0;
    endtask

    // Called just after a falling edge with inputs already set.
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            #1 check_all();
            @(posedge clk);
            model_edge();
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #1 check_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        bus.opcode  = LDA;
        bus.zero    = 1'b0;
        bus.resume  = 1'b0;
        bus.step_en = 1'b0;
        bus.step    = 1'b0;
        @(negedge clk);
        do_reset();

        // Plain LDA instruction.
        tick(8);
        check("lda_retired", 32'(bus.instr_cnt), 32'd1);

        // HLT: hold in phase 4, then resume.
        bus.opcode = HLT;
        tick(5);
        tick(20);
        check("hlt_held_phase", 32'(bus.phase), 32'd4);
        check("hlt_cnt_held", 32'(bus.instr_cnt), 32'd1);
        bus.resume = 1'b1;
        tick();
        bus.resume = 1'b0;
        check("hlt_resume_phase", 32'(bus.phase), 32'd5);
        tick(3);
        check("hlt_retired", 32'(bus.instr_cnt), 32'd2);

        // SKZ both ways, JMP, STO.
        bus.opcode = SKZ; bus.zero = 1'b1; tick(8);
        bus.zero = 1'b0; tick(8);
        bus.opcode = JMP; tick(8);
        bus.opcode = STO; tick(8);

        // Single step from reset, ignored step mid-instruction, release by dropping step_en.
        bus.opcode  = ADD;
        bus.step_en = 1'b1;
        do_reset();
        tick(5);
        check("step_hold_phase", 32'(bus.phase), 32'd0);
        bus.step = 1'b1; tick(); bus.step = 1'b0;
        tick(2);
        bus.step = 1'b1; tick(); bus.step = 1'b0;
        tick(4);
        tick(3);
        check("step_rewait_phase", 32'(bus.phase), 32'd0);
        check("step_rewait_stall", 32'(bus.stalled), 32'd1);
        bus.step_en = 1'b0;
        tick(8);

        // Reset in the middle of phase 5.
        do_reset();
        tick(5);
        do_reset();
        check("midrst_cnt", 32'(bus.instr_cnt), 32'd0);

        // Counter wrap on the narrow instance.
        bus.opcode = ADD;
        tick(32);
        check("wrap_cnt2", 32'(bus2.instr_cnt), 32'd0);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            if (m_phase == 0 && !m_halted) bus.opcode = 3'($urandom_range(0, 7));
            bus.zero   = 1'($urandom_range(0, 1));
            bus.resume = ($urandom_range(0, 7) == 0);
            bus.step   = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 40) == 0) bus.step_en = ~bus.step_en;
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
